// File: rtl/im_fold_fetcher.sv
// im_fold_fetcher: streams NUM_FOLDS item-memory slices
// into a 2-entry FIFO behind a valid/ready handshake.
module im_fold_fetcher #(
  parameter int FOLD_WIDTH      = 500,
  parameter int SRAM_ADDR_WIDTH = 6,
  parameter int NUM_FOLDS       = 20,
  localparam int IW = $clog2(NUM_FOLDS),
  localparam int CW = $clog2(NUM_FOLDS + 1)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start_valid,
  output logic                       start_ready,
  input  logic [SRAM_ADDR_WIDTH-1:0] start_base,
  output logic [SRAM_ADDR_WIDTH-1:0] im_addr,
  input  logic [FOLD_WIDTH-1:0]      im_dout,
  output logic                       fold_valid,
  input  logic                       fold_ready,
  output logic [FOLD_WIDTH-1:0]      fold_data,
  output logic [IW-1:0]              fold_idx,
  output logic                       fold_last,
  output logic                       busy
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN
  } state_t;

  state_t state, state_nxt;

  logic [SRAM_ADDR_WIDTH-1:0] base;
  logic [CW-1:0]              iss;
  logic                       a_v;
  logic [IW-1:0]              a_idx;
  logic                       d_v;
  logic [IW-1:0]              d_idx;
  logic [1:0]                 cnt;
  logic [FOLD_WIDTH-1:0]      h_data;
  logic [FOLD_WIDTH-1:0]      t_data;
  logic [IW-1:0]              h_idx;
  logic [IW-1:0]              t_idx;

  logic       accept;
  logic       pop;
  logic       cap;
  logic       a_left;
  logic       issue;
  logic [1:0] cnt_after;

  assign start_ready = (state == IDLE);
  assign busy        = (state != IDLE);
  assign fold_valid  = (cnt != 2'd0);
  assign fold_data   = h_data;
  assign fold_idx    = h_idx;
  assign fold_last   = fold_valid &&
                       (h_idx == IW'(NUM_FOLDS - 1));

  // A held im_addr re-reads the same word, so a fold
  // dropped on a full FIFO is simply captured again later.
  // Only advance the address when the fold leaving the
  // address stage is sure to find room next cycle.
  always_comb begin
    accept    = start_valid && (state == IDLE);
    pop       = fold_valid && fold_ready;
    cap       = d_v && ((cnt != 2'd2) || pop);
    a_left    = a_v && !(cap && (a_idx == d_idx));
    cnt_after = cnt - {1'b0, pop} + {1'b0, cap};
    issue     = (state == FETCH) &&
                (iss != CW'(NUM_FOLDS)) &&
                (!a_left || (cnt_after != 2'd2));
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (accept) state_nxt = FETCH;
      FETCH: if (issue && (iss == CW'(NUM_FOLDS - 1)))
               state_nxt = DRAIN;
      DRAIN: if (pop && fold_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Address issue and read-pipeline tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base    <= '0;
      im_addr <= '0;
      iss     <= '0;
      a_v     <= 1'b0;
      a_idx   <= '0;
      d_v     <= 1'b0;
      d_idx   <= '0;
    end else begin
      d_v   <= a_left;
      d_idx <= a_idx;
      if (accept) begin
        base    <= start_base;
        im_addr <= start_base;
        iss     <= CW'(1);
        a_v     <= 1'b1;
        a_idx   <= '0;
      end else if (issue) begin
        im_addr <= base + SRAM_ADDR_WIDTH'(iss);
        iss     <= iss + CW'(1);
        a_v     <= 1'b1;
        a_idx   <= iss[IW-1:0];
      end else begin
        a_v     <= a_left;
      end
    end
  end

  // Two-entry FIFO: head feeds the output port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      h_data <= '0;
      h_idx  <= '0;
      t_data <= '0;
      t_idx  <= '0;
    end else begin
      cnt <= cnt_after;
      if (pop) begin
        if (cnt == 2'd2) begin
          h_data <= t_data;
          h_idx  <= t_idx;
          if (cap) begin
            t_data <= im_dout;
            t_idx  <= d_idx;
          end
        end else if (cap) begin
          h_data <= im_dout;
          h_idx  <= d_idx;
        end
      end else if (cap) begin
        if (cnt == 2'd0) begin
          h_data <= im_dout;
          h_idx  <= d_idx;
        end else begin
          t_data <= im_dout;
          t_idx  <= d_idx;
        end
      end
    end
  end

endmodule

// File: tb/tb_im_fold_fetcher.sv
// tb_im_fold_fetcher: directed table plus corner sequences
// against a behavioural item-memory model.
module tb_im_fold_fetcher;

  localparam int FW = 500;
  localparam int AW = 6;
  localparam int N  = 20;
  localparam int IW = $clog2(N);

  logic          clk;
  logic          rst_n;
  logic          start_valid;
  logic          start_ready;
  logic [AW-1:0] start_base;
  logic [AW-1:0] im_addr;
  logic [FW-1:0] im_dout;
  logic          fold_valid;
  logic          fold_ready;
  logic [FW-1:0] fold_data;
  logic [IW-1:0] fold_idx;
  logic          fold_last;
  logic          busy;

  int checks;
  int failures;

  typedef struct {
    logic [AW-1:0] base;
    int            slo;
    int            shi;
    bit            strict;
    bit            gapchk;
    int            maxoff;
    logic [AW-1:0] exp_last;
  } vec_t;

  vec_t vecs[5];

  im_fold_fetcher dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .start_base  (start_base),
    .im_addr     (im_addr),
    .im_dout     (im_dout),
    .fold_valid  (fold_valid),
    .fold_ready  (fold_ready),
    .fold_data   (fold_data),
    .fold_idx    (fold_idx),
    .fold_last   (fold_last),
    .busy        (busy)
  );

  function automatic logic [FW-1:0] mem_word(
    input logic [AW-1:0] a
  );
    logic [31:0] c;
    c = {a, 2'b10, ~a, 2'b01, 16'(a) * 16'd977};
    return FW'({16{c}});
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) im_dout <= mem_word(im_addr);

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string nm,
                     input int act,
                     input int expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %0d want %0d", nm, act, expv);
    end
  endtask

  task automatic chkw(input string nm,
                      input logic [FW-1:0] act,
                      input logic [FW-1:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %h want %h", nm, act, expv);
    end
  endtask

  task automatic run_req(
    input logic [AW-1:0] base,
    input int            slo,
    input int            shi,
    input bit            strict,
    input bit            gapchk,
    input int            maxoff,
    input logic [AW-1:0] exp_last,
    input bit            rnd,
    input bit            hold_sv,
    input int            abort_at,
    input bit            now
  );
    int            rel;
    int            k;
    int            t;
    int            moff;
    int            off;
    bit            done;
    bit            pstall;
    logic [FW-1:0] pd;
    logic [IW-1:0] pi;
    logic          pl;
    logic [AW-1:0] ea;
    if (!now) @(negedge clk);
    t = 0;
    while (!start_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("ready_before_req", int'(start_ready), 1);
    start_valid = 1'b1;
    start_base  = base;
    fold_ready  = 1'b1;
    rel = 0; k = 0; done = 0; pstall = 0; moff = 0;
    pd = '0; pi = '0; pl = 1'b0;
    while (!done && rel < 400) begin
      @(negedge clk);
      rel++;
      if (rel == abort_at) return;
      start_valid = hold_sv;
      start_base  = hold_sv ? (base ^ 6'h21) : base;
      chk("busy_during", int'(busy), 1);
      if (strict && rel <= N) begin
        ea = base + AW'(rel - 1);
        chk("im_addr_seq", int'(im_addr), int'(ea));
      end
      if (strict)
        chk("valid_timing", int'(fold_valid),
            int'(rel >= 3));
      if (strict && rel == N)
        chk("last_addr", int'(im_addr), int'(exp_last));
      if (pstall) begin
        chk("hold_valid", int'(fold_valid), 1);
        chkw("hold_data", fold_data, pd);
        chk("hold_idx", int'(fold_idx), int'(pi));
        chk("hold_last", int'(fold_last), int'(pl));
      end
      if (!fold_valid)
        chk("last_when_idle", int'(fold_last), 0);
      else
        chk("last_flag", int'(fold_last), int'(k == N - 1));
      if (gapchk && maxoff >= 0 &&
          rel >= slo && rel <= shi) begin
        off = int'(AW'(im_addr - base));
        if (off > moff) moff = off;
        if (rel == shi)
          chk("issue_ahead_max",
              (moff <= maxoff) ? maxoff : moff, maxoff);
      end
      if (gapchk && rel > shi && k < N)
        chk("no_gap", int'(fold_valid), 1);
      fold_ready = rnd ? 1'($urandom_range(0, 1))
                       : !(rel >= slo && rel <= shi);
      if (fold_valid && fold_ready) begin
        chk("fold_idx", int'(fold_idx), k);
        ea = base + AW'(k);
        chkw("fold_data", fold_data, mem_word(ea));
        if (strict) chk("xfer_cycle", rel, k + 3);
        if (k == N - 1) done = 1;
        k++;
      end
      pstall = fold_valid && !fold_ready;
      pd = fold_data;
      pi = fold_idx;
      pl = fold_last;
    end
    chk("fold_count", k, N);
    start_valid = hold_sv;
    fold_ready  = 1'b1;
    @(negedge clk);
    chk("ready_after", int'(start_ready), 1);
    chk("busy_after", int'(busy), 0);
    chk("valid_after", int'(fold_valid), 0);
    if (hold_sv) begin
      @(negedge clk);
      start_valid = 1'b0;
      chk("held_req_busy", int'(busy), 1);
      ea = base ^ 6'h21;
      chk("held_req_addr", int'(im_addr), int'(ea));
      t = 0;
      while (!start_ready && t < 100) begin
        @(negedge clk);
        t++;
      end
      chk("held_req_done", int'(start_ready), 1);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_start_ready"}, int'(start_ready), 1);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_fold_valid"}, int'(fold_valid), 0);
    chk({tag, "_fold_last"}, int'(fold_last), 0);
    chk({tag, "_fold_idx"}, int'(fold_idx), 0);
    chkw({tag, "_fold_data"}, fold_data, '0);
    chk({tag, "_im_addr"}, int'(im_addr), 0);
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    rst_n       = 1'b0;
    start_valid = 1'b0;
    start_base  = '0;
    fold_ready  = 1'b0;

    vecs[0] = '{6'd5,  1000, -1, 1'b1, 1'b0, -1, 6'd24};
    vecs[1] = '{6'd60, 1000, -1, 1'b1, 1'b0, -1, 6'd15};
    vecs[2] = '{6'd5,  4,    9,  1'b0, 1'b1, 3,  6'd0};
    vecs[3] = '{6'd63, 6,    8,  1'b0, 1'b1, -1, 6'd0};
    vecs[4] = '{6'd0,  1000, -1, 1'b1, 1'b0, -1, 6'd19};

    #1;
    chk_reset_vals("por");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++)
      run_req(vecs[i].base, vecs[i].slo, vecs[i].shi,
              vecs[i].strict, vecs[i].gapchk,
              vecs[i].maxoff, vecs[i].exp_last,
              1'b0, 1'b0, -1, 1'b0);

    run_req(6'd12, 1000, -1, 1'b1, 1'b0, -1, 6'd31,
            1'b0, 1'b1, -1, 1'b0);

    run_req(6'd9, 1000, -1, 1'b1, 1'b0, -1, 6'd28,
            1'b0, 1'b0, 10, 1'b0);
    rst_n       = 1'b0;
    start_valid = 1'b0;
    #1;
    chk_reset_vals("mid_req");
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_req(6'd0, 1000, -1, 1'b1, 1'b0, -1, 6'd19,
            1'b0, 1'b0, -1, 1'b1);

    for (int r = 0; r < 100; r++)
      run_req(AW'($urandom_range(0, 63)), 1000, -1,
              1'b0, 1'b0, -1, 6'd0,
              1'b1, 1'b0, -1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/im_fold_fetcher.md
IM_FOLD_FETCHER -- requirements
Module: im_fold_fetcher

Interface
REQ-001 Parameter FOLD_WIDTH, default 500, SHALL set the bit width of one folded hypervector slice (im_dout / fold_data).
REQ-002 Parameter SRAM_ADDR_WIDTH, default 6, SHALL set the item-memory SRAM address width.
REQ-003 Parameter NUM_FOLDS, default 20, SHALL set the folds fetched per request (2 <= NUM_FOLDS <= 2^SRAM_ADDR_WIDTH).
REQ-004 clk  in  1  SHALL be the single clock; all state changes on its rising edge.
REQ-005 rst_n  in  1  SHALL be the asynchronous, active-low reset.
REQ-006 start_valid  in  1  SHALL mean a fetch request is offered.
REQ-007 start_ready  out  1  SHALL mean the block accepts a request this cycle.
REQ-008 start_base  in  SRAM_ADDR_WIDTH  SHALL be the SRAM address of fold 0.
REQ-009 im_addr  out  SRAM_ADDR_WIDTH  SHALL be the registered read address to the item-memory wrapper (always enabled, 1-cycle read latency).
REQ-010 im_dout  in  FOLD_WIDTH  SHALL be the wrapper read data for the address presented in the previous cycle.
REQ-011 fold_valid / fold_ready  out / in  1 / 1  SHALL form the downstream handshake; a transfer occurs when both are high at a rising edge.
REQ-012 fold_data  out  FOLD_WIDTH  SHALL be the current fold slice.
REQ-013 fold_idx  out  $clog2(NUM_FOLDS)  SHALL be the fold number of fold_data.
REQ-014 fold_last  out  1  SHALL be high when fold_idx == NUM_FOLDS-1 and fold_valid is high.
REQ-015 busy  out  1  SHALL be high from request acceptance until the last fold transfers.

Function
REQ-016 States IDLE, FETCH, DRAIN: IDLE->FETCH on start_valid && start_ready; FETCH->DRAIN once all NUM_FOLDS addresses are issued; DRAIN->IDLE on transfer of the fold with fold_last high.
REQ-017 start_ready SHALL equal (state == IDLE); start_valid SHALL be ignored in FETCH and DRAIN.
REQ-018 On acceptance, start_base SHALL be latched; fold k SHALL be read from (base + k) mod 2^SRAM_ADDR_WIDTH, with wrap-around and no error.
REQ-019 Read data SHALL be captured into a 2-entry FIFO at the end of the cycle after its address is issued; fold_data/fold_idx/fold_last SHALL come from the FIFO head registers.
REQ-020 A new address SHALL be issued only if (FIFO occupancy + outstanding reads - head pop this cycle) < 2; the FIFO SHALL never overflow and no fold SHALL be lost or duplicated.
REQ-021 When no address is issued, im_addr SHALL hold its previous value and the returning data SHALL be discarded.
REQ-022 Latency: request accepted in cycle C0 -> im_addr = base in C1 -> fold 0 fold_valid high in C3.
REQ-023 With fold_ready held high, one fold SHALL transfer per cycle (C3 .. C3+NUM_FOLDS-1); start_ready SHALL be high in the cycle after the last transfer.
REQ-024 While fold_valid is high and fold_ready is low, fold_data, fold_idx and fold_last SHALL stay stable.
REQ-025 Folds SHALL be delivered in order, with fold_idx 0..NUM_FOLDS-1.
REQ-026 fold_ready while fold_valid is low SHALL have no effect.

Reset
REQ-027 Asserting rst_n low SHALL immediately force: state IDLE, start_ready 1, busy 0, fold_valid 0, fold_last 0, fold_idx 0, fold_data 0, im_addr 0, FIFO empty, outstanding reads 0.
REQ-028 Reset mid-request SHALL abandon the request; the first cycle after rst_n rises SHALL accept a new request.

Verification
REQ-029 Streaming: base=5, NUM_FOLDS=20, fold_ready=1 -> im_addr 5..24 in C1..C20; fold_idx 0..19 in C3..C22; fold_last only in C22; start_ready=1 in C23.
REQ-030 Wrap: SRAM_ADDR_WIDTH=6, base=60 -> addresses 60,61,62,63,0,1,...,15; data matches the memory model at each address.
REQ-031 Backpressure: fold_ready low C4..C9 -> fold 1 held stable; at most 2 addresses beyond fold 1 issued; after release, folds 1..19 arrive with no gaps or duplicates.
REQ-032 Random fold_ready (50%) over 100 requests -> every request delivers exactly NUM_FOLDS in-order folds; FIFO occupancy + outstanding reads <= 2 at all times.
REQ-033 start_valid held high during FETCH -> ignored; next request accepted only in IDLE.
REQ-034 rst_n pulsed low in C10 of a request -> all REQ-027 values are seen in the same cycle; a new request with base=0 then completes normally.
